// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI defaults, burst/response encodings and FSM state types
package axi_pkg;
  localparam int D_ID_WIDTH = 4;
  localparam int D_ADDR_WIDTH = 32;
  localparam int D_DATA_WIDTH = 32;
  typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2} axi_burst_e;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} axi_resp_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: next beat address and wrap legality; WRAP support only with AXI_SLV_MEM_WRAP_EN
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = D_ADDR_WIDTH
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              err
);
  logic [ADDR_W-1:0] step, incr;
  assign step = ADDR_W'(1) << size;
  assign incr = addr + step;
`ifdef AXI_SLV_MEM_WRAP_EN
  logic [ADDR_W-1:0] span, bound;
  assign span = (ADDR_W'(len) + ADDR_W'(1)) << size;
  assign bound = addr & ~(span - ADDR_W'(1));
  assign next_addr = burst == FIXED ? addr : (burst == WRAP && incr == bound + span) ? bound : incr;
  assign err = burst == WRAP && (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (addr & (step - ADDR_W'(1))) != '0);
`else
  logic unused_len;
  assign unused_len = ^len;
  assign next_addr = burst == FIXED ? addr : incr;
  assign err = burst == WRAP;
`endif
endmodule

// File: rtl/axi_slv_mem.sv
// axi_slv_mem: AXI4 slave RAM responder with independent write/read FSMs; AXI_SLV_MEM_WRAP_EN enables WRAP bursts
module axi_slv_mem
  import axi_pkg::*;
#(
  parameter int ID_W = D_ID_WIDTH,
  parameter int ADDR_W = D_ADDR_WIDTH,
  parameter int DATA_W = D_DATA_WIDTH,
  parameter int MEM_WORDS = 256
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic [2:0]          AWPROT,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [ID_W-1:0]     WID,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [7:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic [2:0]          ARPROT,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int LW = $clog2(MEM_WORDS);
  localparam logic [2:0] MAX_SIZE = 3'(LB);
  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic live;
  w_state_e w_st, w_nx;
  r_state_e r_st, r_nx;
  logic [ID_W-1:0] w_id, r_id;
  logic [ADDR_W-1:0] w_addr, r_addr, wg_next, rg_next;
  logic [7:0] w_len, r_len, w_cnt, r_cnt;
  logic [2:0] w_size, r_size;
  logic [1:0] w_burst, r_burst, r_resp;
  logic [DATA_W-1:0] r_data;
  logic w_err, r_err, wg_err, rg_err;
  logic aw_hs, w_hs, ar_hs, r_hs, w_final, r_final, w_beat_err, w_we, ar_err, rn_err;
  logic unused_in;

  function automatic logic oor(input logic [ADDR_W-1:0] a);
    return |(a >> (LB + LW));
  endfunction

  function automatic logic [LW-1:0] widx(input logic [ADDR_W-1:0] a);
    return a[LB +: LW];
  endfunction

  function automatic logic ax_err(input logic [ADDR_W-1:0] a, input logic [2:0] s, input logic [1:0] b);
    return s > MAX_SIZE || oor(a) || b == 2'd3;
  endfunction

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs = RVALID && RREADY;
  assign w_final = w_cnt == w_len;
  assign r_final = r_cnt == r_len;
  assign w_beat_err = (WLAST != w_final) || oor(w_addr);
  assign w_we = w_hs && !w_err && !w_beat_err;
  assign ar_err = ax_err(ARADDR, ARSIZE, ARBURST) || rg_err;
  assign rn_err = r_err || oor(rg_next);
  assign unused_in = ^{AWPROT, ARPROT, WID};

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_wgen (
    .addr(w_st == W_IDLE ? AWADDR : w_addr),
    .size(w_st == W_IDLE ? AWSIZE : w_size),
    .len(w_st == W_IDLE ? AWLEN : w_len),
    .burst(w_st == W_IDLE ? AWBURST : w_burst),
    .next_addr(wg_next),
    .err(wg_err)
  );

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_rgen (
    .addr(r_st == R_IDLE ? ARADDR : r_addr),
    .size(r_st == R_IDLE ? ARSIZE : r_size),
    .len(r_st == R_IDLE ? ARLEN : r_len),
    .burst(r_st == R_IDLE ? ARBURST : r_burst),
    .next_addr(rg_next),
    .err(rg_err)
  );

  // holds address READYs low until the first edge after reset release
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) live <= 1'b0;
    else live <= 1'b1;

  // write FSM state register
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) w_st <= W_IDLE;
    else w_st <= w_nx;

  // write FSM next state
  always_comb
    w_nx = (w_st == W_IDLE && aw_hs) ? W_DATA :
           (w_st == W_DATA && w_hs && w_final) ? W_RESP :
           (w_st == W_RESP && BREADY) ? W_IDLE : w_st;

  // write channel outputs
  always_comb begin
    AWREADY = live && w_st == W_IDLE;
    WREADY = w_st == W_DATA;
    BVALID = w_st == W_RESP;
    BID = w_id;
    BRESP = w_err ? SLVERR : OKAY;
  end

  // write burst context: latched at AW, advanced per W beat, error is sticky
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      w_id <= '0;
      w_addr <= '0;
      w_len <= '0;
      w_size <= '0;
      w_burst <= '0;
      w_err <= 1'b0;
      w_cnt <= '0;
    end else if (aw_hs) begin
      w_id <= AWID;
      w_addr <= AWADDR;
      w_len <= AWLEN;
      w_size <= AWSIZE;
      w_burst <= AWBURST;
      w_err <= ax_err(AWADDR, AWSIZE, AWBURST) || wg_err;
      w_cnt <= '0;
    end else if (w_hs) begin
      w_err <= w_err || w_beat_err;
      w_addr <= wg_next;
      w_cnt <= w_cnt + 8'd1;
    end

  // byte-lane RAM write; erroring beats and bursts never commit
  always_ff @(posedge ACLK)
    if (w_we)
      for (int i = 0; i < NB; i++)
        if (WSTRB[i]) mem[widx(w_addr)][i*8 +: 8] <= WDATA[i*8 +: 8];

  // read FSM state register
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) r_st <= R_IDLE;
    else r_st <= r_nx;

  // read FSM next state
  always_comb
    r_nx = (r_st == R_IDLE && ar_hs) ? R_DATA :
           (r_st == R_DATA && r_hs && r_final) ? R_IDLE : r_st;

  // read channel outputs
  always_comb begin
    ARREADY = live && r_st == R_IDLE;
    RVALID = r_st == R_DATA;
    RID = r_id;
    RDATA = r_data;
    RRESP = r_resp;
    RLAST = r_st == R_DATA && r_final;
  end

  // read burst context and registered beat data, fetched at AR and on each accepted beat
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      r_id <= '0;
      r_addr <= '0;
      r_len <= '0;
      r_size <= '0;
      r_burst <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
      r_data <= '0;
      r_resp <= OKAY;
    end else if (ar_hs) begin
      r_id <= ARID;
      r_addr <= ARADDR;
      r_len <= ARLEN;
      r_size <= ARSIZE;
      r_burst <= ARBURST;
      r_err <= ar_err;
      r_cnt <= '0;
      r_data <= ar_err ? '0 : mem[widx(ARADDR)];
      r_resp <= ar_err ? SLVERR : OKAY;
    end else if (r_hs && !r_final) begin
      r_addr <= rg_next;
      r_cnt <= r_cnt + 8'd1;
      r_data <= rn_err ? '0 : mem[widx(rg_next)];
      r_resp <= rn_err ? SLVERR : OKAY;
    end
endmodule
